// File: rtl/tl_tx_flow_control_credit_gate_pkg.sv
// Shared flow-control definitions: FC state encoding, per-scale field widths
// and the field-mask helper used by the TX credit gate.
package tl_fc_pkg;

   typedef enum logic {
      FC_INIT   = 1'b0,
      FC_ACTIVE = 1'b1
   } fc_state_t;

   localparam int HDR_FIELD_W_S0  = 8;
   localparam int HDR_FIELD_W_S2  = 10;
   localparam int HDR_FIELD_W_S3  = 12;
   localparam int DATA_FIELD_W_S0 = 12;
   localparam int DATA_FIELD_W_S2 = 14;
   localparam int DATA_FIELD_W_S3 = 16;
   localparam int FC_MASK_W       = 16;

   // Scale 2'b00 and 2'b01 share the unscaled field width.
   function automatic logic [FC_MASK_W-1:0] fc_field_mask(input logic [1:0] scale,
                                                          input logic       is_data);
      int w;
      case (scale)
         2'b10:   w = is_data ? DATA_FIELD_W_S2 : HDR_FIELD_W_S2;
         2'b11:   w = is_data ? DATA_FIELD_W_S3 : HDR_FIELD_W_S3;
         default: w = is_data ? DATA_FIELD_W_S0 : HDR_FIELD_W_S0;
      endcase
      return FC_MASK_W'((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/tl_tx_flow_control_credit_gate_if.sv
// DLL flow-control and TX-arbiter handshake bundle for one FC credit gate.
interface tl_tx_flow_control_credit_gate_if #(
   parameter int FC_HDR_CREDS_WIDTH   = 12,
   parameter int FC_DATA_CREDS_WIDTH  = 16,
   parameter int DLL_HDR_CREDS_WIDTH  = 12,
   parameter int DLL_DATA_CREDS_WIDTH = 16
);
   logic                            dll_valid;
   logic                            dll_init;
   logic                            dll_fc_error;
   logic [DLL_HDR_CREDS_WIDTH-1:0]  dll_hdr_creds;
   logic [DLL_DATA_CREDS_WIDTH-1:0] dll_data_creds;
   logic [1:0]                      dll_hdr_scale;
   logic [1:0]                      dll_data_scale;
   logic                            tlp_req;
   logic [FC_HDR_CREDS_WIDTH-1:0]   tlp_hdr_req;
   logic [FC_DATA_CREDS_WIDTH-1:0]  tlp_data_req;
   logic                            tlp_gnt;
   logic                            fc_init_done;
   logic [FC_HDR_CREDS_WIDTH-1:0]   hdr_creds_avail;
   logic [FC_DATA_CREDS_WIDTH-1:0]  data_creds_avail;

   modport master (
      output dll_valid, dll_init, dll_fc_error, dll_hdr_creds, dll_data_creds,
             dll_hdr_scale, dll_data_scale, tlp_req, tlp_hdr_req, tlp_data_req,
      input  tlp_gnt, fc_init_done, hdr_creds_avail, data_creds_avail
   );

   modport slave (
      input  dll_valid, dll_init, dll_fc_error, dll_hdr_creds, dll_data_creds,
             dll_hdr_scale, dll_data_scale, tlp_req, tlp_hdr_req, tlp_data_req,
      output tlp_gnt, fc_init_done, hdr_creds_avail, data_creds_avail
   );
endinterface

// File: rtl/tl_tx_flow_control_credit_gate_credit_check.sv
// Modular credit gating compare: a TLP fits when the wrapped remainder after
// taking it lies in the lower half of the credit field.
module tl_tx_fc_credit_check #(
   parameter int W = 12
) (
   input  logic [W-1:0] limit,
   input  logic [W-1:0] consumed,
   input  logic [W-1:0] request,
   input  logic [W-1:0] mask,
   input  logic         infinite,
   output logic         ok
);
   logic [W-1:0] diff;
   logic [W-1:0] half;

   assign diff = (limit - (consumed + request)) & mask;
   assign half = (mask >> 1) + W'(1);
   assign ok   = infinite | (diff <= half);
endmodule

// File: rtl/tl_tx_flow_control_credit_gate.sv
// TX flow-control credit gate for one FC type: tracks advertised limit and
// consumed credits and grants a pending TLP only when both classes fit.
module tl_tx_flow_control_credit_gate
   import tl_fc_pkg::*;
#(
   parameter int FC_HDR_CREDS_WIDTH   = 12,
   parameter int FC_DATA_CREDS_WIDTH  = 16,
   parameter int DLL_HDR_CREDS_WIDTH  = 12,
   parameter int DLL_DATA_CREDS_WIDTH = 16
) (
   input logic                             clk,
   input logic                             rst_n,
   input logic                             link_up,
   tl_tx_flow_control_credit_gate_if.slave fc
);
   localparam int HW = FC_HDR_CREDS_WIDTH;
   localparam int DW = FC_DATA_CREDS_WIDTH;

   fc_state_t state, state_nx;

   logic [HW-1:0] lim_h, lim_h_nx, cons_h, cons_h_nx, avail_h, avail_h_nx;
   logic [DW-1:0] lim_d, lim_d_nx, cons_d, cons_d_nx, avail_d, avail_d_nx;
   logic [1:0]    hscale, hscale_nx, dscale, dscale_nx;
   logic          inf_h, inf_h_nx, inf_d, inf_d_nx;
   logic          gnt, gnt_nx;

   logic [DLL_HDR_CREDS_WIDTH-1:0]  dll_hdr;
   logic [DLL_DATA_CREDS_WIDTH-1:0] dll_data;
   logic [HW-1:0] hdr_in, hmask, hmask_nx;
   logic [DW-1:0] data_in, dmask, dmask_nx;
   logic          init_ok, upd_ok, ok_h, ok_d, grant;

   assign dll_hdr  = fc.dll_hdr_creds;
   assign dll_data = fc.dll_data_creds;
   assign hdr_in   = HW'(dll_hdr);
   assign data_in  = DW'(dll_data);
   assign init_ok  = fc.dll_valid &  fc.dll_init & ~fc.dll_fc_error;
   assign upd_ok   = fc.dll_valid & ~fc.dll_init & ~fc.dll_fc_error;
   assign hmask    = HW'(fc_field_mask(hscale, 1'b0));
   assign dmask    = DW'(fc_field_mask(dscale, 1'b1));

   tl_tx_fc_credit_check #(.W(HW)) u_hdr_check (
      .limit    (lim_h),
      .consumed (cons_h),
      .request  (fc.tlp_hdr_req),
      .mask     (hmask),
      .infinite (inf_h),
      .ok       (ok_h)
   );

   tl_tx_fc_credit_check #(.W(DW)) u_data_check (
      .limit    (lim_d),
      .consumed (cons_d),
      .request  (fc.tlp_data_req),
      .mask     (dmask),
      .infinite (inf_d),
      .ok       (ok_d)
   );

   // No back-to-back grants: the cycle showing gnt never grants again.
   assign grant = (state == FC_ACTIVE) & link_up & fc.tlp_req & ok_h & ok_d & ~gnt;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= FC_INIT;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (!link_up)                          state_nx = FC_INIT;
      else if (state == FC_INIT && init_ok)  state_nx = FC_ACTIVE;
   end

   always_comb begin
      lim_h_nx  = lim_h;
      lim_d_nx  = lim_d;
      cons_h_nx = cons_h;
      cons_d_nx = cons_d;
      hscale_nx = hscale;
      dscale_nx = dscale;
      inf_h_nx  = inf_h;
      inf_d_nx  = inf_d;
      gnt_nx    = 1'b0;
      if (!link_up) begin
         lim_h_nx  = '0;
         lim_d_nx  = '0;
         cons_h_nx = '0;
         cons_d_nx = '0;
         hscale_nx = '0;
         dscale_nx = '0;
         inf_h_nx  = 1'b0;
         inf_d_nx  = 1'b0;
      end else begin
         case (state)
            FC_INIT: begin
               if (init_ok) begin
                  hscale_nx = fc.dll_hdr_scale;
                  dscale_nx = fc.dll_data_scale;
                  lim_h_nx  = hdr_in  & HW'(fc_field_mask(fc.dll_hdr_scale, 1'b0));
                  lim_d_nx  = data_in & DW'(fc_field_mask(fc.dll_data_scale, 1'b1));
                  inf_h_nx  = (dll_hdr == '0);
                  inf_d_nx  = (dll_data == '0);
               end
            end
            default: begin
               // The grant decision below uses the pre-update limit.
               if (upd_ok) begin
                  if (!inf_h) lim_h_nx = hdr_in & hmask;
                  if (!inf_d) lim_d_nx = data_in & dmask;
               end
               if (grant) begin
                  gnt_nx = 1'b1;
                  if (!inf_h) cons_h_nx = (cons_h + fc.tlp_hdr_req) & hmask;
                  if (!inf_d) cons_d_nx = (cons_d + fc.tlp_data_req) & dmask;
               end
            end
         endcase
      end
      hmask_nx   = HW'(fc_field_mask(hscale_nx, 1'b0));
      dmask_nx   = DW'(fc_field_mask(dscale_nx, 1'b1));
      avail_h_nx = inf_h_nx ? '1 : ((lim_h_nx - cons_h_nx) & hmask_nx);
      avail_d_nx = inf_d_nx ? '1 : ((lim_d_nx - cons_d_nx) & dmask_nx);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lim_h   <= '0;
         lim_d   <= '0;
         cons_h  <= '0;
         cons_d  <= '0;
         hscale  <= '0;
         dscale  <= '0;
         inf_h   <= 1'b0;
         inf_d   <= 1'b0;
         gnt     <= 1'b0;
         avail_h <= '0;
         avail_d <= '0;
      end else begin
         lim_h   <= lim_h_nx;
         lim_d   <= lim_d_nx;
         cons_h  <= cons_h_nx;
         cons_d  <= cons_d_nx;
         hscale  <= hscale_nx;
         dscale  <= dscale_nx;
         inf_h   <= inf_h_nx;
         inf_d   <= inf_d_nx;
         gnt     <= gnt_nx;
         avail_h <= avail_h_nx;
         avail_d <= avail_d_nx;
      end
   end

   assign fc.tlp_gnt          = gnt;
   assign fc.fc_init_done     = (state == FC_ACTIVE);
   assign fc.hdr_creds_avail  = avail_h;
   assign fc.data_creds_avail = avail_d;

endmodule

// File: tb/tb_tl_tx_flow_control_credit_gate.sv
// Directed bench for the TX FC credit gate with a grant scoreboard.
module tb_tl_tx_flow_control_credit_gate;

   logic clk = 1'b0;
   logic rst_n;
   logic link_up;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      int    h;
      int    d;
      string tag;
   } exp_t;
   exp_t exp_q[$];

   tl_tx_flow_control_credit_gate_if bus ();

   tl_tx_flow_control_credit_gate dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .link_up (link_up),
      .fc      (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_dllp(input bit init, input int h, input int d,
                            input bit [1:0] hs, input bit [1:0] ds, input bit err);
      bus.dll_valid      = 1'b1;
      bus.dll_init       = init;
      bus.dll_fc_error   = err;
      bus.dll_hdr_creds  = 12'(h);
      bus.dll_data_creds = 16'(d);
      bus.dll_hdr_scale  = hs;
      bus.dll_data_scale = ds;
      tick();
      bus.dll_valid      = 1'b0;
      bus.dll_fc_error   = 1'b0;
   endtask

   task automatic check_avail(input string tag, input int h, input int d);
      check({tag, " hdr_avail"}, 32'(bus.hdr_creds_avail), h);
      check({tag, " data_avail"}, 32'(bus.data_creds_avail), d);
   endtask

   task automatic await_gnt(input int exp_lat);
      exp_t e;
      int   n = 0;
      do begin
         tick();
         n++;
      end while (bus.tlp_gnt !== 1'b1 && n < 16);
      if (exp_q.size() == 0) begin
         check("scoreboard underflow", 32'(exp_q.size()), 1);
      end else begin
         e = exp_q.pop_front();
         check({e.tag, " latency"}, n, exp_lat);
         check_avail(e.tag, e.h, e.d);
      end
      bus.tlp_req = 1'b0;
      tick();
      check("gnt one-cycle pulse", 32'(bus.tlp_gnt), 0);
   endtask

   task automatic grant(input int hreq, input int dreq, input int eh, input int ed,
                        input string tag);
      exp_q.push_back('{h: eh, d: ed, tag: tag});
      bus.tlp_hdr_req  = 12'(hreq);
      bus.tlp_data_req = 16'(dreq);
      bus.tlp_req      = 1'b1;
      await_gnt(1);
   endtask

   task automatic hold(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         tick();
         check(tag, 32'(bus.tlp_gnt), 0);
      end
   endtask

   task automatic link_drop(input string tag);
      link_up = 1'b0;
      tick();
      check({tag, " init_done"}, 32'(bus.fc_init_done), 0);
      check_avail(tag, 0, 0);
      link_up = 1'b1;
   endtask

   initial begin
      rst_n              = 1'b0;
      link_up            = 1'b0;
      bus.dll_valid      = 1'b0;
      bus.dll_init       = 1'b0;
      bus.dll_fc_error   = 1'b0;
      bus.dll_hdr_creds  = '0;
      bus.dll_data_creds = '0;
      bus.dll_hdr_scale  = '0;
      bus.dll_data_scale = '0;
      bus.tlp_req        = 1'b0;
      bus.tlp_hdr_req    = '0;
      bus.tlp_data_req   = '0;
      tick();
      tick();
      check("reset gnt", 32'(bus.tlp_gnt), 0);
      check("reset init_done", 32'(bus.fc_init_done), 0);
      check_avail("reset", 0, 0);
      rst_n   = 1'b1;
      link_up = 1'b1;
      tick();
      check("idle init_done", 32'(bus.fc_init_done), 0);

      // 1: basic InitFC and a single grant
      send_dllp(1'b1, 8, 64, 2'b00, 2'b00, 1'b0);
      check("t1 init_done", 32'(bus.fc_init_done), 1);
      check_avail("t1 after init", 8, 64);
      grant(1, 4, 7, 60, "t1 grant");

      // 2: header limit exhaustion then release by UpdateFC
      link_drop("t2 drop");
      send_dllp(1'b1, 8, 64, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 8; i++) grant(1, 0, 7 - i, 64, $sformatf("t2 grant%0d", i));
      exp_q.push_back('{h: 0, d: 64, tag: "t2 ninth"});
      bus.tlp_hdr_req  = 12'd1;
      bus.tlp_data_req = 16'd0;
      bus.tlp_req      = 1'b1;
      hold(3, "t2 ninth held");
      send_dllp(1'b0, 9, 64, 2'b00, 2'b00, 1'b0);
      check("t2 no gnt on update edge", 32'(bus.tlp_gnt), 0);
      check("t2 avail after update", 32'(bus.hdr_creds_avail), 1);
      await_gnt(1);

      // 3: infinite credits
      link_drop("t3 drop");
      send_dllp(1'b1, 0, 0, 2'b00, 2'b00, 1'b0);
      check_avail("t3 after init", 'hFFF, 'hFFFF);
      for (int i = 0; i < 1000; i++) grant(1, 4, 'hFFF, 'hFFFF, "t3 grant");
      send_dllp(1'b0, 5, 5, 2'b00, 2'b00, 1'b0);
      check_avail("t3 update ignored", 'hFFF, 'hFFFF);

      // 4: 8-bit header wrap-around
      link_drop("t4 drop");
      send_dllp(1'b1, 250, 0, 2'b00, 2'b00, 1'b0);
      check_avail("t4 after init", 250, 'hFFFF);
      grant(250, 4, 0, 'hFFFF, "t4 bulk");
      send_dllp(1'b0, 4, 0, 2'b00, 2'b00, 1'b0);
      check("t4 avail after wrap update", 32'(bus.hdr_creds_avail), 10);
      for (int i = 0; i < 10; i++) grant(1, 1, 9 - i, 'hFFFF, $sformatf("t4 wrap%0d", i));
      bus.tlp_hdr_req = 12'd1;
      bus.tlp_req     = 1'b1;
      hold(3, "t4 exhausted held");
      bus.tlp_req     = 1'b0;
      tick();

      // 5: discarded and out-of-state DLLPs, scale 2'b10 masking
      link_drop("t5 drop");
      send_dllp(1'b1, 600, 3000, 2'b10, 2'b10, 1'b0);
      check_avail("t5 after init", 600, 3000);
      send_dllp(1'b0, 700, 4000, 2'b10, 2'b10, 1'b1);
      check_avail("t5 fc_error update", 600, 3000);
      send_dllp(1'b1, 50, 50, 2'b10, 2'b10, 1'b0);
      check_avail("t5 initfc in active", 600, 3000);
      send_dllp(1'b0, 1030, 3000, 2'b10, 2'b10, 1'b0);
      check("t5 10-bit masked limit", 32'(bus.hdr_creds_avail), 6);
      grant(1, 1, 5, 2999, "t5 grant");
      link_drop("t5 drop2");
      send_dllp(1'b0, 40, 40, 2'b00, 2'b00, 1'b0);
      check("t5 updatefc in init", 32'(bus.fc_init_done), 0);
      check_avail("t5 updatefc in init", 0, 0);
      bus.tlp_req = 1'b1;
      hold(2, "t5 no gnt in init");
      bus.tlp_req = 1'b0;

      // 6: link loss and reset while a request is pending
      send_dllp(1'b1, 8, 64, 2'b00, 2'b00, 1'b0);
      check("t6 init_done", 32'(bus.fc_init_done), 1);
      bus.tlp_hdr_req  = 12'd1;
      bus.tlp_data_req = 16'd1;
      bus.tlp_req      = 1'b1;
      link_up          = 1'b0;
      tick();
      check("t6 link loss gnt", 32'(bus.tlp_gnt), 0);
      check("t6 link loss init_done", 32'(bus.fc_init_done), 0);
      check_avail("t6 link loss", 0, 0);
      link_up = 1'b1;
      hold(2, "t6 no gnt after link loss");
      bus.tlp_req = 1'b0;
      send_dllp(1'b1, 8, 64, 2'b00, 2'b00, 1'b0);
      bus.tlp_req = 1'b1;
      tick();
      check("t6 gnt before reset", 32'(bus.tlp_gnt), 1);
      rst_n       = 1'b0;
      bus.tlp_req = 1'b0;
      tick();
      check("t6 reset gnt", 32'(bus.tlp_gnt), 0);
      check("t6 reset init_done", 32'(bus.fc_init_done), 0);
      check_avail("t6 reset", 0, 0);
      rst_n = 1'b1;
      tick();

      check("scoreboard drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
